// File: rtl/delay_estimator.sv
// Sweeps candidate bit delays between ref_in and dly_in, keeping the one with the fewest mismatches.
// Optional: DELAY_ESTIMATOR_EARLY_STOP_EN ends the sweep at the first zero-mismatch candidate.
module delay_estimator #(
  parameter int LENGTH = 63,
  parameter int WIDTH  = 4,
  parameter int WINDOW = 64,
  parameter int SEL_W  = $clog2((LENGTH+1)*WIDTH),
  parameter int CNT_W  = $clog2(WINDOW*WIDTH+1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             ena,
  input  logic [WIDTH-1:0] ref_in,
  input  logic [WIDTH-1:0] dly_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic [SEL_W-1:0] sel_out,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int HW    = (LENGTH+1)*WIDTH;
  localparam int NCAND = LENGTH*WIDTH+1;
  localparam int FW    = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int WW    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [SEL_W-1:0] LAST_D   = SEL_W'(NCAND-1);
  localparam logic [FW-1:0]    FILL_END = FW'(LENGTH-1);
  localparam logic [WW-1:0]    WIN_END  = WW'(WINDOW-1);

  typedef enum logic [2:0] {IDLE, FILL, MEASURE, EVAL, DONE} state_t;

  state_t                  state_q, state_d;
  logic [HW-WIDTH-1:0]     hist_q, hist_d;
  logic [FW-1:0]           fill_q, fill_d;
  logic [WW-1:0]           win_q, win_d;
  logic [SEL_W-1:0]        d_q, d_d;
  logic [SEL_W-1:0]        bsel_q, bsel_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [CNT_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]        best_q, best_d;
  logic [CNT_W-1:0]        err_q, err_d;
  logic                    valid_q, valid_d;
  logic [HW-1:0]           hist;
  logic [WIDTH-1:0]        win;

  function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Element 0 is the live ref_in; higher elements are progressively older samples.
  assign hist = {hist_q, ref_in};
  assign win  = hist[d_q +: WIDTH];

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign valid   = valid_q;
  assign sel_out = sel_q;
  assign err_cnt = err_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      win_q   <= '0;
      d_q     <= '0;
      bsel_q  <= '0;
      sel_q   <= '0;
      acc_q   <= '0;
      best_q  <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      win_q   <= win_d;
      d_q     <= d_d;
      bsel_q  <= bsel_d;
      sel_q   <= sel_d;
      acc_q   <= acc_d;
      best_q  <= best_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hist_d  = ena ? hist[HW-WIDTH-1:0] : hist_q;
    fill_d  = fill_q;
    win_d   = win_q;
    d_d     = d_q;
    bsel_d  = bsel_q;
    sel_d   = sel_q;
    acc_d   = acc_q;
    best_d  = best_q;
    err_d   = err_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          fill_d  = '0;
          win_d   = '0;
          d_d     = '0;
          acc_d   = '0;
          best_d  = '1;
          valid_d = 1'b0;
        end
      end
      FILL: begin
        if (ena) begin
          if (fill_q == FILL_END) begin
            state_d = MEASURE;
            d_d     = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
      end
      MEASURE: begin
        if (ena) begin
          acc_d = acc_q + popcnt(dly_in ^ win);
          if (win_q == WIN_END) begin
            win_d   = '0;
            state_d = EVAL;
          end else begin
            win_d = win_q + 1'b1;
          end
        end
      end
      EVAL: begin
        acc_d = '0;
        // Strict compare keeps the lowest candidate on ties.
        if (acc_q < best_q) begin
          best_d = acc_q;
          bsel_d = d_q;
        end
`ifdef DELAY_ESTIMATOR_EARLY_STOP_EN
        if (acc_q == '0 || d_q == LAST_D) begin
          state_d = DONE;
        end else begin
          d_d     = d_q + 1'b1;
          state_d = MEASURE;
        end
`else
        if (d_q == LAST_D) begin
          state_d = DONE;
        end else begin
          d_d     = d_q + 1'b1;
          state_d = MEASURE;
        end
`endif
      end
      DONE: begin
        sel_d   = bsel_q;
        err_d   = best_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
